// File: rtl/fp32_normalizer.sv
// FP32 adder post-add normalizer: carry renormalize, iterative
// leading-zero removal down to the denormal floor, valid/ready output.
module fp32_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [22:0] out_frac,
    output logic [4:0]  out_lz,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic [7:0]  r_e;
    logic [23:0] r_mant;
    logic [4:0]  r_lz;

    logic        w_accept;
    logic [7:0]  w_e;
    logic [7:0]  w_e_inc;
    logic        w_needs_shift;
    logic        w_shift_stop;

    // Zero exponent shares the 2^-126 scale of exponent 1
    assign w_e      = (in_exp == 8'd0) ? 8'd1 : in_exp;
    assign w_e_inc  = w_e + 8'd1;
    assign w_accept = in_valid && (r_state == IDLE);

    assign w_needs_shift = (in_exp != 8'hFF)
                        && (in_mant != 25'd0)
                        && !in_mant[24]
                        && !in_mant[23];

    assign w_shift_stop = r_mant[23] || (r_e == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_needs_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_shift_stop) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_e      <= 8'd0;
            r_mant   <= 24'd0;
            r_lz     <= 5'd0;
            out_sign <= 1'b0;
            out_exp  <= 8'd0;
            out_frac <= 23'd0;
            out_lz   <= 5'd0;
            out_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_sign <= in_sign;
            r_e    <= w_e;
            r_mant <= in_mant[23:0];
            r_lz   <= 5'd0;
            if (!w_needs_shift) begin
                out_sign <= in_sign;
                out_lz   <= 5'd0;
                out_ovf  <= 1'b0;
            end
            if (in_exp == 8'hFF) begin
                out_exp  <= 8'hFF;
                out_frac <= in_mant[22:0];
            end else if (in_mant == 25'd0) begin
                out_exp  <= 8'd0;
                out_frac <= 23'd0;
            end else if (in_mant[24]) begin
                out_exp <= w_e_inc;
                if (w_e_inc == 8'hFF) begin
                    out_frac <= 23'd0;
                    out_ovf  <= 1'b1;
                end else begin
                    out_frac <= in_mant[23:1];
                end
            end else if (in_mant[23]) begin
                out_exp  <= w_e;
                out_frac <= in_mant[22:0];
            end
        end else if (r_state == SHIFT) begin
            if (w_shift_stop) begin
                out_sign <= r_sign;
                out_exp  <= r_mant[23] ? r_e : 8'd0;
                out_frac <= r_mant[22:0];
                out_lz   <= r_lz;
                out_ovf  <= 1'b0;
            end else begin
                r_mant <= {r_mant[22:0], 1'b0};
                r_e    <= r_e - 8'd1;
                r_lz   <= r_lz + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_normalizer.sv
// Directed-vector bench for fp32_normalizer with
// backpressure and mid-shift reset sequences.
module tb_fp32_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic [4:0]  out_lz;
    logic        out_ovf;

    int n_vec;
    int n_bad;

    fp32_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_lz    (out_lz),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [7:0]  xe;
        logic [22:0] xf;
        logic [4:0]  xlz;
        logic        xovf;
        int          lat;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Accept, wait for out_valid, check, then pop the result
    task automatic run_vec(input int idx, input vec_t t);
        int lat;
        in_sign  = t.s;
        in_exp   = t.e;
        in_mant  = t.m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, t.lat);
        chk($sformatf("v%0d sign", idx), out_sign, t.s);
        chk($sformatf("v%0d exp", idx), out_exp, t.xe);
        chk($sformatf("v%0d frac", idx), out_frac, t.xf);
        chk($sformatf("v%0d lz", idx), out_lz, t.xlz);
        chk($sformatf("v%0d ovf", idx), out_ovf, t.xovf);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d pop valid", idx), out_valid, 1'b0);
        chk($sformatf("v%0d pop ready", idx), in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0]  se;
        logic [22:0] sf;
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_mant   = 25'd0;
        out_ready = 1'b0;

        v[0]  = '{1'b0, 8'h80, 25'h0800000, 8'h80, 23'h000000, 5'd0,  1'b0, 1};
        v[1]  = '{1'b0, 8'h7F, 25'h1800000, 8'h80, 23'h400000, 5'd0,  1'b0, 1};
        v[2]  = '{1'b1, 8'h85, 25'h0000100, 8'h76, 23'h000000, 5'd15, 1'b0, 17};
        v[3]  = '{1'b0, 8'h03, 25'h0000100, 8'h00, 23'h000400, 5'd2,  1'b0, 4};
        v[4]  = '{1'b0, 8'hFE, 25'h1000000, 8'hFF, 23'h000000, 5'd0,  1'b1, 1};
        v[5]  = '{1'b1, 8'h40, 25'h0000000, 8'h00, 23'h000000, 5'd0,  1'b0, 1};
        v[6]  = '{1'b0, 8'hFF, 25'h0400001, 8'hFF, 23'h400001, 5'd0,  1'b0, 1};
        v[7]  = '{1'b1, 8'h80, 25'h0000001, 8'h69, 23'h000000, 5'd23, 1'b0, 25};
        v[8]  = '{1'b0, 8'h00, 25'h0200000, 8'h00, 23'h200000, 5'd0,  1'b0, 2};
        v[9]  = '{1'b0, 8'h00, 25'h0800001, 8'h01, 23'h000001, 5'd0,  1'b0, 1};
        v[10] = '{1'b1, 8'h10, 25'h1FFFFFF, 8'h11, 23'h7FFFFF, 5'd0,  1'b0, 1};
        v[11] = '{1'b0, 8'h20, 25'h0400000, 8'h1F, 23'h000000, 5'd1,  1'b0, 3};
        v[12] = '{1'b0, 8'h00, 25'h1000000, 8'h02, 23'h000000, 5'd0,  1'b0, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_exp", out_exp, 8'h00);
        chk("rst out_frac", out_frac, 23'h0);
        chk("rst out_lz", out_lz, 5'd0);
        chk("rst out_ovf", out_ovf, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(i, v[i]);
        end

        // Backpressure: hold the result for 5 cycles
        in_sign  = 1'b1;
        in_exp   = 8'h7F;
        in_mant  = 25'h1800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp valid", out_valid, 1'b1);
        se = out_exp;
        sf = out_frac;
        chk("bp exp", se, 8'h80);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid", out_valid, 1'b1);
            chk("bp hold ready", in_ready, 1'b0);
            chk("bp hold exp", out_exp, se);
            chk("bp hold frac", out_frac, sf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release valid", out_valid, 1'b0);
        chk("bp release ready", in_ready, 1'b1);
        chk("bp idle hold exp", out_exp, 8'h80);
        chk("bp idle hold frac", out_frac, 23'h400000);

        // Reset in the middle of a long shift sequence
        in_sign  = 1'b0;
        in_exp   = 8'h85;
        in_mant  = 25'h0000100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid ready low", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", out_valid, 1'b0);
        chk("mid rst ready", in_ready, 1'b1);
        chk("mid rst exp", out_exp, 8'h00);
        chk("mid rst frac", out_frac, 23'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(100, v[3]);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
